axi_mem_responder: RTL and testbench

- AXI4 slave memory model: the responder end of the kernel's m00_axi master port (AW/W/B/AR/R subset, INCR bursts only).
- Sits in the kernel simulation harness and in loopback builds in place of the platform memory.
- Backs an on-chip word array and serves the master's awlen/arlen bursts.
- Exposes completed-burst counters and a sticky protocol-error flag for checkers.

---
 rtl/axi_mem_responder_if.sv | 37 +++
 rtl/axi_mem_responder.sv | 155 +++++++++++++++
 tb/tb_axi_mem_responder.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_mem_responder_if.sv
// AXI4 AW/W/B/AR/R subset carried between the kernel master and the memory responder.
interface axi_mem_responder_if #(
    parameter int unsigned C_ADDR_WIDTH = 64,
    parameter int unsigned C_DATA_WIDTH = 512
);
    logic                        awvalid;
    logic                        awready;
    logic [C_ADDR_WIDTH-1:0]     awaddr;
    logic [7:0]                  awlen;
    logic                        wvalid;
    logic                        wready;
    logic [C_DATA_WIDTH-1:0]     wdata;
    logic [C_DATA_WIDTH/8-1:0]   wstrb;
    logic                        wlast;
    logic                        bvalid;
    logic                        bready;
    logic                        arvalid;
    logic                        arready;
    logic [C_ADDR_WIDTH-1:0]     araddr;
    logic [7:0]                  arlen;
    logic                        rvalid;
    logic                        rready;
    logic [C_DATA_WIDTH-1:0]     rdata;
    logic                        rlast;

    modport master (
        output awvalid, awaddr, awlen, wvalid, wdata, wstrb, wlast, bready,
               arvalid, araddr, arlen, rready,
        input  awready, wready, bvalid, arready, rvalid, rdata, rlast
    );

    modport slave (
        input  awvalid, awaddr, awlen, wvalid, wdata, wstrb, wlast, bready,
               arvalid, araddr, arlen, rready,
        output awready, wready, bvalid, arready, rvalid, rdata, rlast
    );
endinterface

// File: rtl/axi_mem_responder.sv
// AXI4 slave memory model: on-chip word array serving INCR bursts, one outstanding
// transaction per direction, with burst counters and a sticky wlast error flag.
module axi_mem_responder #(
    parameter int unsigned C_ADDR_WIDTH      = 64,
    parameter int unsigned C_DATA_WIDTH      = 512,
    parameter int unsigned C_MEM_DEPTH_WORDS = 256
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    axi_mem_responder_if.slave   s_axi,
    output logic [31:0]          wr_burst_cnt,
    output logic [31:0]          rd_burst_cnt,
    output logic                 err_wlast
);
    localparam int unsigned STRB_W = C_DATA_WIDTH / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);
    localparam int unsigned IDX_W  = $clog2(C_MEM_DEPTH_WORDS);

    typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
    typedef enum logic [1:0] {RIdle, RLoad, RData} r_state_e;

    logic [C_DATA_WIDTH-1:0] mem [C_MEM_DEPTH_WORDS];

    w_state_e                w_state;
    logic                    awready_q, wready_q, bvalid_q;
    logic [IDX_W-1:0]        w_idx;
    logic [7:0]              w_len, w_cnt;

    r_state_e                r_state;
    logic                    arready_q, rvalid_q, rlast_q;
    logic [C_DATA_WIDTH-1:0] rdata_q;
    logic [IDX_W-1:0]        r_idx, r_idx_inc;
    logic [7:0]              r_len, r_cnt;

    logic                    unused_addr;

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rlast   = rlast_q;
    assign r_idx_inc     = r_idx + IDX_W'(1);
    assign unused_addr   = ^{s_axi.awaddr, s_axi.araddr};

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            w_state      <= WIdle;
            awready_q    <= 1'b0;
            wready_q     <= 1'b0;
            bvalid_q     <= 1'b0;
            w_idx        <= '0;
            w_len        <= '0;
            w_cnt        <= '0;
            wr_burst_cnt <= '0;
            err_wlast    <= 1'b0;
        end else begin
            unique case (w_state)
                WIdle: begin
                    awready_q <= 1'b1;
                    if (s_axi.awvalid && awready_q) begin
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        w_idx     <= s_axi.awaddr[OFF_W +: IDX_W];
                        w_len     <= s_axi.awlen;
                        w_cnt     <= '0;
                        w_state   <= WData;
                    end
                end
                WData: begin
                    if (s_axi.wvalid && wready_q) begin
                        w_idx <= w_idx + IDX_W'(1);
                        w_cnt <= w_cnt + 8'd1;
                        if (s_axi.wlast != (w_cnt == w_len)) err_wlast <= 1'b1;
                        // Beat count, not wlast, terminates the burst.
                        if (w_cnt == w_len) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            w_state  <= WResp;
                        end
                    end
                end
                WResp: begin
                    if (s_axi.bready && bvalid_q) begin
                        bvalid_q     <= 1'b0;
                        awready_q    <= 1'b1;
                        wr_burst_cnt <= wr_burst_cnt + 32'd1;
                        w_state      <= WIdle;
                    end
                end
                default: w_state <= WIdle;
            endcase
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst_n && wready_q && s_axi.wvalid) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (s_axi.wstrb[b]) mem[w_idx][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
            end
        end
    end

    // Reads sample mem with non-blocking semantics, so a same-cycle write is not seen.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_state      <= RIdle;
            arready_q    <= 1'b0;
            rvalid_q     <= 1'b0;
            rlast_q      <= 1'b0;
            rdata_q      <= '0;
            r_idx        <= '0;
            r_len        <= '0;
            r_cnt        <= '0;
            rd_burst_cnt <= '0;
        end else begin
            unique case (r_state)
                RIdle: begin
                    arready_q <= 1'b1;
                    if (s_axi.arvalid && arready_q) begin
                        arready_q <= 1'b0;
                        r_idx     <= s_axi.araddr[OFF_W +: IDX_W];
                        r_len     <= s_axi.arlen;
                        r_cnt     <= '0;
                        r_state   <= RLoad;
                    end
                end
                RLoad: begin
                    rdata_q  <= mem[r_idx];
                    rvalid_q <= 1'b1;
                    rlast_q  <= (r_len == 8'd0);
                    r_state  <= RData;
                end
                RData: begin
                    if (s_axi.rready && rvalid_q) begin
                        if (rlast_q) begin
                            rvalid_q     <= 1'b0;
                            rlast_q      <= 1'b0;
                            arready_q    <= 1'b1;
                            rd_burst_cnt <= rd_burst_cnt + 32'd1;
                            r_state      <= RIdle;
                        end else begin
                            r_idx   <= r_idx_inc;
                            r_cnt   <= r_cnt + 8'd1;
                            rdata_q <= mem[r_idx_inc];
                            rlast_q <= ((r_cnt + 8'd1) == r_len);
                        end
                    end
                end
                default: r_state <= RIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_mem_responder.sv
// Scoreboard bench for axi_mem_responder: model memory predicts read data at AR time.
module tb_axi_mem_responder;
    localparam int unsigned AW = 64;
    localparam int unsigned DW = 512;
    localparam int unsigned DEPTH = 256;
    localparam int GUARD = 1000;

    logic ap_clk = 1'b0;
    logic ap_rst_n = 1'b0;
    logic [31:0] wr_burst_cnt, rd_burst_cnt;
    logic err_wlast;

    axi_mem_responder_if #(.C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW)) bus ();

    axi_mem_responder #(
        .C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW), .C_MEM_DEPTH_WORDS(DEPTH)
    ) dut (
        .ap_clk(ap_clk),
        .ap_rst_n(ap_rst_n),
        .s_axi(bus),
        .wr_burst_cnt(wr_burst_cnt),
        .rd_burst_cnt(rd_burst_cnt),
        .err_wlast(err_wlast)
    );

    always #5 ap_clk = ~ap_clk;

    int tests = 0;
    int fails = 0;
    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] exp_data_q [$];
    logic          exp_last_q [$];
    int exp_wr_cnt = 0;
    int exp_rd_cnt = 0;

    task automatic write_burst(input logic [AW-1:0] addr, input int len, input logic [DW-1:0] pat,
                               input logic [DW/8-1:0] strb, input int last_at);
        int idx, guard, b_lat;
        logic [DW-1:0] d;
        idx = int'(addr[13:6]);
        @(negedge ap_clk);
        bus.awvalid = 1'b1; bus.awaddr = addr; bus.awlen = 8'(len);
        guard = 0;
        while (!bus.awready && guard < GUARD) begin @(negedge ap_clk); guard++; end
        tests++;
        if (guard >= GUARD) begin fails++; $display("FAIL aw_timeout: awready got 0 required 1"); end
        @(negedge ap_clk);
        bus.awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            d = pat + DW'(i);
            bus.wvalid = 1'b1; bus.wdata = d; bus.wstrb = strb; bus.wlast = (i == last_at);
            guard = 0;
            while (!bus.wready && guard < GUARD) begin @(negedge ap_clk); guard++; end
            if (guard >= GUARD) begin
                tests++; fails++; $display("FAIL w_timeout: wready got 0 required 1");
            end
            for (int b = 0; b < DW/8; b++) if (strb[b]) model_mem[idx][b*8 +: 8] = d[b*8 +: 8];
            idx = (idx + 1) % DEPTH;
            @(negedge ap_clk);
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        bus.bready = 1'b1;
        b_lat = 0;
        while (!bus.bvalid && b_lat < GUARD) begin @(negedge ap_clk); b_lat++; end
        tests++;
        if (b_lat != 0) begin
            fails++; $display("FAIL b_latency: bvalid after %0d extra cycles, required 0", b_lat);
        end
        @(negedge ap_clk);
        bus.bready = 1'b0;
        exp_wr_cnt++;
        tests++;
        if (wr_burst_cnt !== 32'(exp_wr_cnt)) begin
            fails++; $display("FAIL wr_burst_cnt: got %0d required %0d", wr_burst_cnt, exp_wr_cnt);
        end
        tests++;
        if (bus.bvalid !== 1'b0) begin fails++; $display("FAIL bvalid_drop: got 1 required 0"); end
    endtask

    task automatic read_burst(input logic [AW-1:0] addr, input int len, input bit toggle);
        int idx, guard, lat, beats;
        bit held;
        logic [DW-1:0] held_data, ed;
        logic el;
        idx = int'(addr[13:6]);
        for (int i = 0; i <= len; i++) begin
            exp_data_q.push_back(model_mem[(idx + i) % DEPTH]);
            exp_last_q.push_back(i == len);
        end
        @(negedge ap_clk);
        bus.arvalid = 1'b1; bus.araddr = addr; bus.arlen = 8'(len); bus.rready = 1'b0;
        guard = 0;
        while (!bus.arready && guard < GUARD) begin @(negedge ap_clk); guard++; end
        tests++;
        if (guard >= GUARD) begin fails++; $display("FAIL ar_timeout: arready got 0 required 1"); end
        lat = 0;
        @(negedge ap_clk); lat++;
        bus.arvalid = 1'b0;
        while (!bus.rvalid && lat < GUARD) begin @(negedge ap_clk); lat++; end
        tests++;
        if (lat != 2) begin fails++; $display("FAIL r_latency: got %0d cycles required 2", lat); end
        beats = 0; held = 1'b0; held_data = '0; guard = 0;
        bus.rready = 1'b0;
        while (beats <= len && guard < 4 * GUARD) begin
            bus.rready = toggle ? ~bus.rready : 1'b1;
            if (bus.rvalid) begin
                if (held) begin
                    tests++;
                    if (bus.rdata !== held_data) begin
                        fails++; $display("FAIL rdata_stable: got %0h required %0h", bus.rdata, held_data);
                    end
                end
                if (bus.rready) begin
                    ed = exp_data_q.pop_front();
                    el = exp_last_q.pop_front();
                    tests++;
                    if (bus.rdata !== ed) begin
                        fails++; $display("FAIL rdata beat %0d: got %0h required %0h", beats, bus.rdata, ed);
                    end
                    tests++;
                    if (bus.rlast !== el) begin
                        fails++; $display("FAIL rlast beat %0d: got %0b required %0b", beats, bus.rlast, el);
                    end
                    beats++;
                    held = 1'b0;
                end else begin
                    held = 1'b1; held_data = bus.rdata;
                end
            end
            @(negedge ap_clk);
            guard++;
        end
        bus.rready = 1'b0;
        tests++;
        if (beats != len + 1) begin
            fails++; $display("FAIL r_timeout: got %0d beats required %0d", beats, len + 1);
        end
        exp_rd_cnt++;
        tests++;
        if (rd_burst_cnt !== 32'(exp_rd_cnt)) begin
            fails++; $display("FAIL rd_burst_cnt: got %0d required %0d", rd_burst_cnt, exp_rd_cnt);
        end
    endtask

    task automatic check_idle_reset(input string tag);
        logic [7:0] got;
        got = {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.rlast,
               err_wlast, 1'b0};
        tests++;
        if (got !== 8'h00 || bus.rdata !== '0 || wr_burst_cnt !== 0 || rd_burst_cnt !== 0) begin
            fails++;
            $display("FAIL %s: flags %0h rdata %0h wr %0d rd %0d required all 0", tag, got,
                     bus.rdata, wr_burst_cnt, rd_burst_cnt);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge ap_clk);
        check_idle_reset("reset_outputs");
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        tests++;
        if (bus.awready !== 1'b1 || bus.arready !== 1'b1) begin
            fails++; $display("FAIL ready_after_reset: aw %0b ar %0b required 1 1", bus.awready, bus.arready);
        end
    endtask

    task automatic test_single_write();
        write_burst(64'h40, 0, {64{8'hA5}}, '1, 0);
        tests++;
        if (err_wlast !== 1'b0) begin fails++; $display("FAIL err_wlast_clean: got 1 required 0"); end
        read_burst(64'h40, 0, 1'b0);
    endtask

    task automatic test_burst_readback();
        write_burst(64'h0, 15, '0, '1, 15);
        read_burst(64'h0, 15, 1'b0);
    endtask

    task automatic test_strobes_backpressure();
        write_burst(64'h800, 3, '1, '1, 3);
        write_burst(64'h800, 3, {16{32'h1234_5670}}, 64'h0000_0000_0000_000F, 3);
        tests++;
        if (model_mem[32][DW-1:32] !== '1) begin
            fails++; $display("FAIL strobe_model: upper bytes got %0h required all ones", model_mem[32]);
        end
        read_burst(64'h800, 3, 1'b1);
    endtask

    task automatic test_wrap();
        write_burst(64'h3FC0, 1, {8{64'hC0FFEE00_00000000}}, '1, 1);
        read_burst(64'h0, 0, 1'b0);
        read_burst(64'h3FC0, 1, 1'b0);
    endtask

    task automatic test_wlast_error();
        write_burst(64'h1000, 3, {16{32'hBAD0_0000}}, '1, 2);
        tests++;
        if (err_wlast !== 1'b1) begin fails++; $display("FAIL err_wlast_set: got 0 required 1"); end
        write_burst(64'h1100, 1, {16{32'h600D_0000}}, '1, 1);
        tests++;
        if (err_wlast !== 1'b1) begin fails++; $display("FAIL err_wlast_sticky: got 0 required 1"); end
        read_burst(64'h1000, 3, 1'b0);
    endtask

    task automatic test_long_burst();
        write_burst(64'h0, 255, {16{32'h5A5A_0000}}, '1, 255);
        read_burst(64'h0, 255, 1'b0);
    endtask

    task automatic test_concurrency_reset();
        int guard;
        fork
            write_burst(64'h1900, 7, {16{32'h7700_0000}}, '1, 7);
            read_burst(64'h0, 7, 1'b0);
        join
        read_burst(64'h1900, 7, 1'b0);
        // Start a read and abandon it mid-burst with reset.
        @(negedge ap_clk);
        bus.arvalid = 1'b1; bus.araddr = 64'h1900; bus.arlen = 8'd7; bus.rready = 1'b0;
        guard = 0;
        while (!bus.arready && guard < GUARD) begin @(negedge ap_clk); guard++; end
        @(negedge ap_clk);
        bus.arvalid = 1'b0;
        guard = 0;
        while (!bus.rvalid && guard < GUARD) begin @(negedge ap_clk); guard++; end
        tests++;
        if (bus.rvalid !== 1'b1) begin fails++; $display("FAIL rst_pre_rvalid: got 0 required 1"); end
        ap_rst_n = 1'b0;
        @(negedge ap_clk);
        tests++;
        if (bus.rvalid !== 1'b0 || bus.arready !== 1'b0) begin
            fails++; $display("FAIL rst_mid_read: rvalid %0b arready %0b required 0 0", bus.rvalid, bus.arready);
        end
        check_idle_reset("rst_mid_outputs");
        ap_rst_n = 1'b1;
        exp_wr_cnt = 0; exp_rd_cnt = 0;
        @(negedge ap_clk);
        tests++;
        if (bus.arready !== 1'b1) begin fails++; $display("FAIL arready_after_rst: got 0 required 1"); end
        read_burst(64'h1900, 7, 1'b1);
    endtask

    initial begin
        bus.awvalid = 1'b0; bus.awaddr = '0; bus.awlen = '0;
        bus.wvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
        bus.bready = 1'b0;
        bus.arvalid = 1'b0; bus.araddr = '0; bus.arlen = '0; bus.rready = 1'b0;
        test_reset();
        test_single_write();
        test_burst_readback();
        test_strobes_backpressure();
        test_wrap();
        test_wlast_error();
        test_long_burst();
        test_concurrency_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
